// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer holding DEPTH x 32-bit registers.
// Programmable wait states per transfer; pslverr on bad address.
// Ports: hclk, hreset_n (async, active-low); APB psel, penable,
//   pwrite, paddr, pwdata, prdata, pready, pslverr; wait_num
//   (wait states, sampled at setup); err_cnt (saturating errors).
// Optional: APB_SLV_PSTRB_EN adds pstrb[3:0] byte strobes.
module apb_slave_regbank #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [3:0]            pstrb,
`endif
  input  logic [3:0]            wait_num,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  write_q;
  logic                  err_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic                  setup_err;
  logic [IW-1:0]         setup_idx;
  logic [3:0]            wr_strb;

  assign setup_idx = paddr[IW+1:2];

`ifdef APB_SLV_PSTRB_EN
  logic [3:0] strb_q;

  // A read carrying strobes is rejected.
  assign setup_err = (paddr[1:0] != 2'b00)
                   || (32'(paddr[ADDR_WIDTH-1:2]) >= DEPTH)
                   || (!pwrite && (pstrb != 4'h0));
  assign wr_strb   = strb_q;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      strb_q <= 4'h0;
    end else if (state == IDLE && psel && !penable) begin
      strb_q <= pstrb;
    end
  end
`else
  assign setup_err = (paddr[1:0] != 2'b00)
                   || (32'(paddr[ADDR_WIDTH-1:2]) >= DEPTH);
  assign wr_strb   = 4'hF;
`endif

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      err_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (psel && !penable) begin
            write_q <= pwrite;
            wdata_q <= pwdata;
            err_q   <= setup_err;
            idx_q   <= setup_idx;
            cnt     <= wait_num;
            state   <= ACCESS;
            // Zero-wait: respond in the first access cycle.
            if (wait_num == 4'd0) begin
              pready  <= 1'b1;
              pslverr <= setup_err;
              if (!pwrite) begin
                prdata <= setup_err ? '0
                                    : regs[setup_idx];
              end
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end else if (!pready) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= err_q;
              if (!write_q) begin
                prdata <= err_q ? '0 : regs[idx_q];
              end
            end
          end else if (penable) begin
            if (write_q && !err_q) begin
              for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                  regs[idx_q][8*b +: 8] <=
                    wdata_q[8*b +: 8];
                end
              end
            end
            if (err_q && err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed vectors for apb_slave_regbank.
// Table of transfers plus abort, strobe, saturation, reset cases.
module tb_apb_slave_regbank;

  logic        hclk;
  logic        hreset_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  wait_num;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  apb_slave_regbank dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
`ifdef APB_SLV_PSTRB_EN
    .pstrb    (pstrb),
`endif
    .wait_num (wait_num),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .err_cnt  (err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wn;
    int          exp_waits;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after completion.
  task automatic xfer(input logic wr,
                      input logic [7:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [3:0] wn,
                      output logic [31:0] rd,
                      output logic er,
                      output int waits,
                      output logic ok);
    rd = '0;
    er = 1'b0;
    ok = 1'b0;
    waits = 0;
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    pstrb = s;
    wait_num = wn;
    @(negedge hclk);
    penable = 1'b1;
    // Must not affect the transfer already in flight.
    wait_num = ~wn;
    for (int i = 0; i < 40; i++) begin
      if (pready) begin
        ok = 1'b1;
        rd = prdata;
        er = pslverr;
        break;
      end
      waits++;
      @(negedge hclk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL timeout: pready never rose");
    end
    @(negedge hclk);
    psel = 1'b0;
    penable = 1'b0;
  endtask

  vec_t        vt [17];
  logic [31:0] rd;
  logic        er;
  int          wt;
  logic        ok;

  initial begin
    vt[0]  = '{0, 8'h08, 32'h0, 4'd0, 0, 0, 32'h0};
    vt[1]  = '{1, 8'h04, 32'hDEADBEEF, 4'd3, 3, 0, 32'h0};
    vt[2]  = '{0, 8'h04, 32'h0, 4'd1, 1, 0, 32'hDEADBEEF};
    vt[3]  = '{1, 8'h00, 32'h11, 4'd2, 2, 0, 32'h0};
    vt[4]  = '{1, 8'h04, 32'h22, 4'd0, 0, 0, 32'h0};
    vt[5]  = '{1, 8'h08, 32'h33, 4'd3, 3, 0, 32'h0};
    vt[6]  = '{1, 8'h0C, 32'h44, 4'd1, 1, 0, 32'h0};
    vt[7]  = '{1, 8'h10, 32'h55, 4'd0, 0, 0, 32'h0};
    vt[8]  = '{0, 8'h00, 32'h0, 4'd0, 0, 0, 32'h11};
    vt[9]  = '{0, 8'h04, 32'h0, 4'd1, 1, 0, 32'h22};
    vt[10] = '{0, 8'h08, 32'h0, 4'd2, 2, 0, 32'h33};
    vt[11] = '{0, 8'h0C, 32'h0, 4'd3, 3, 0, 32'h44};
    vt[12] = '{0, 8'h10, 32'h0, 4'd0, 0, 0, 32'h55};
    vt[13] = '{1, 8'h40, 32'hBAD, 4'd1, 1, 1, 32'h0};
    vt[14] = '{0, 8'h06, 32'h0, 4'd2, 2, 1, 32'h0};
    vt[15] = '{0, 8'h3C, 32'h0, 4'd0, 0, 0, 32'h0};
    vt[16] = '{0, 8'h00, 32'h0, 4'd0, 0, 0, 32'h11};

    hreset_n = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    wait_num = '0;
    repeat (3) @(negedge hclk);
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    hreset_n = 1'b1;
    @(negedge hclk);

    for (int i = 0; i < 17; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata,
           vt[i].wr ? 4'hF : 4'h0, vt[i].wn,
           rd, er, wt, ok);
      chk($sformatf("v%0d_waits", i), wt, vt[i].exp_waits);
      chk($sformatf("v%0d_err", i), {31'b0, er},
          {31'b0, vt[i].exp_err});
      if (!vt[i].wr) begin
        chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      end
    end
    chk("tbl_err_cnt", {24'b0, err_cnt}, 32'd2);

    // Abort a write to 0x0C after one wait cycle.
    psel = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h0C;
    pwdata = 32'h99;
    pstrb = 4'hF;
    wait_num = 4'd3;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge hclk);
    chk("abort_pready", {31'b0, pready}, 32'h0);
    xfer(0, 8'h0C, 0, 4'h0, 4'd0, rd, er, wt, ok);
    chk("abort_waits", wt, 0);
    chk("abort_reg", rd, 32'h44);
    chk("abort_err_cnt", {24'b0, err_cnt}, 32'd2);

`ifdef APB_SLV_PSTRB_EN
    xfer(1, 8'h00, 32'hAABBCCDD, 4'hF, 4'd0,
         rd, er, wt, ok);
    xfer(1, 8'h00, 32'h11223344, 4'b0101, 4'd1,
         rd, er, wt, ok);
    xfer(1, 8'h00, 32'hFFFFFFFF, 4'h0, 4'd0,
         rd, er, wt, ok);
    chk("strb0_err", {31'b0, er}, 32'h0);
    xfer(0, 8'h00, 0, 4'h0, 4'd0, rd, er, wt, ok);
    chk("strb_rdata", rd, 32'hAA22CC44);
    xfer(0, 8'h00, 0, 4'b0001, 4'd0, rd, er, wt, ok);
    chk("strb_rd_err", {31'b0, er}, 32'h1);
    chk("strb_rd_data", rd, 32'h0);
    chk("strb_err_cnt", {24'b0, err_cnt}, 32'd3);
`endif

    // Saturate the error counter.
    for (int i = 0; i < 260; i++) begin
      xfer(0, 8'h01, 0, 4'h0, 4'd0, rd, er, wt, ok);
    end
    chk("sat_err_cnt", {24'b0, err_cnt}, 32'd255);

    // Reset while pready is high on a write to 0x08.
    psel = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h08;
    pwdata = 32'h77;
    pstrb = 4'hF;
    wait_num = 4'd0;
    @(negedge hclk);
    penable = 1'b1;
    chk("pre_rst_pready", {31'b0, pready}, 32'h1);
    hreset_n = 1'b0;
    #1;
    chk("mid_rst_pready", {31'b0, pready}, 32'h0);
    chk("mid_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    @(negedge hclk);
    psel = 1'b0;
    penable = 1'b0;
    hreset_n = 1'b1;
    @(negedge hclk);
    xfer(0, 8'h08, 0, 4'h0, 4'd0, rd, er, wt, ok);
    chk("rst_reg08", rd, 32'h0);
    xfer(0, 8'h04, 0, 4'h0, 4'd1, rd, er, wt, ok);
    chk("rst_reg04", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
